// File: rtl/fib_seq_gen.sv
// fib_seq_gen: Fibonacci-class sequence generator with programmable seeds,
// term count, valid/ready output stream, overflow tagging and optional
// saturation.
//
// Optional feature macro: FIB_SEQ_GEN_INDEX_EN adds out_index (0-based term index).
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              one-cycle burst request, sampled only in IDLE
//   seed0, seed1       first and second terms, captured on accepted start
//   term_count         number of terms to emit (0 = request ignored)
//   out_valid/ready    output stream handshake
//   out_data           current term
//   out_last           high with the final term of a burst
//   busy               high while a burst is running
//   ovf                sticky overflow flag for the current/last burst
//   out_index          (FIB_SEQ_GEN_INDEX_EN only) index of the current term
module fib_seq_gen #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] term_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
`ifdef FIB_SEQ_GEN_INDEX_EN
  output logic [CNT_W-1:0] out_index,
`endif
  output logic             ovf
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b;
  logic             a_ovf, b_ovf;
  logic [CNT_W-1:0] remaining;

  logic             accept_c, hs_c, final_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] next_c;

  // Widened sum so the carry out of the top bit is visible.
  assign sum_c  = {1'b0, a} + {1'b0, b};
  assign next_c = ((SATURATE != 0) && sum_c[WIDTH]) ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];

  assign out_data = a;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    hs_c      = 1'b0;
    final_c   = 1'b0;
    case (state)
      IDLE: begin
        accept_c = start && (term_count != '0);
        if (accept_c) state_nxt = RUN;
      end
      RUN: begin
        hs_c    = out_ready;
        final_c = out_ready && (remaining == CNT_W'(1));
        if (final_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Term pipeline, counters and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      a_ovf     <= 1'b0;
      b_ovf     <= 1'b0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept_c) begin
      a         <= seed0;
      b         <= seed1;
      a_ovf     <= 1'b0;
      b_ovf     <= 1'b0;
      remaining <= term_count;
      out_valid <= 1'b1;
      out_last  <= (term_count == CNT_W'(1));
      busy      <= 1'b1;
      ovf       <= 1'b0;
    end else if (hs_c) begin
      remaining <= remaining - CNT_W'(1);
      if (final_c) begin
        // a keeps the last term so out_data holds it in IDLE.
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        a         <= b;
        a_ovf     <= b_ovf;
        b         <= next_c;
        b_ovf     <= sum_c[WIDTH] | a_ovf | b_ovf;
        out_last  <= (remaining == CNT_W'(2));
        // ovf rises together with the first tagged term reaching out_data.
        ovf       <= ovf | b_ovf;
      end
    end
  end

`ifdef FIB_SEQ_GEN_INDEX_EN
  // Index of the term currently presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out_index <= '0;
    else if (accept_c) out_index <= '0;
    else if (hs_c)     out_index <= out_index + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed self-checking bench for fib_seq_gen: one 16-bit instance plus
// wrapping and saturating 8-bit instances sharing a stimulus set.
module tb_fib_seq_gen;

  logic        clk;
  logic        rst;

  logic        start;
  logic [15:0] seed0, seed1;
  logic [7:0]  tc;
  logic        ready;
  logic        valid, last, busy, ovf;
  logic [15:0] data;

  logic        start8;
  logic [7:0]  seed0_8, seed1_8;
  logic [7:0]  tc8;
  logic        ready8;
  logic        w_valid, w_last, w_busy, w_ovf;
  logic [7:0]  w_data;
  logic        s_valid, s_last, s_busy, s_ovf;
  logic [7:0]  s_data;

`ifdef FIB_SEQ_GEN_INDEX_EN
  logic [7:0]  idx16, idx_w, idx_s;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  fib_seq_gen #(.WIDTH(16), .CNT_W(8), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .term_count(tc), .out_valid(valid), .out_ready(ready), .out_data(data),
    .out_last(last), .busy(busy),
`ifdef FIB_SEQ_GEN_INDEX_EN
    .out_index(idx16),
`endif
    .ovf(ovf));

  fib_seq_gen #(.WIDTH(8), .CNT_W(8), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .start(start8), .seed0(seed0_8), .seed1(seed1_8),
    .term_count(tc8), .out_valid(w_valid), .out_ready(ready8), .out_data(w_data),
    .out_last(w_last), .busy(w_busy),
`ifdef FIB_SEQ_GEN_INDEX_EN
    .out_index(idx_w),
`endif
    .ovf(w_ovf));

  fib_seq_gen #(.WIDTH(8), .CNT_W(8), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .start(start8), .seed0(seed0_8), .seed1(seed1_8),
    .term_count(tc8), .out_valid(s_valid), .out_ready(ready8), .out_data(s_data),
    .out_last(s_last), .busy(s_busy),
`ifdef FIB_SEQ_GEN_INDEX_EN
    .out_index(idx_s),
`endif
    .ovf(s_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs a 16-bit burst with out_ready high, checking each beat against exp_q.
  // A start pulse with other seeds is injected at beat 'mid' (if >= 0).
  task automatic run16(input string name, input int n, input logic [15:0] s0,
                       input logic [15:0] s1, input int mid);
    seed0 = s0; seed1 = s1; tc = 8'(n); ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s data[%0d]", name, i), 32'(data), 32'(exp_q[i]));
      check($sformatf("%s last[%0d]", name, i), 32'(last), 32'(i == n - 1));
      check($sformatf("%s valid[%0d]", name, i), 32'(valid), 32'd1);
      check($sformatf("%s busy[%0d]", name, i), 32'(busy), 32'd1);
      check($sformatf("%s ovf[%0d]", name, i), 32'(ovf), 32'd0);
      if (i == mid) begin
        start = 1'b1; seed0 = 16'd5; seed1 = 16'd5; tc = 8'd9;
      end
      step();
      start = 1'b0;
    end
    check({name, " valid_end"}, 32'(valid), 32'd0);
    check({name, " busy_end"}, 32'(busy), 32'd0);
    check({name, " data_hold"}, 32'(data), 32'(exp_q[n-1]));
  endtask

  initial begin
    int idx, stall;
    logic tog;

    rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; tc = '0; ready = 1'b1;
    start8 = 1'b0; seed0_8 = '0; seed1_8 = '0; tc8 = '0; ready8 = 1'b1;
    #12;
    check("rst valid", 32'(valid), 32'd0);
    check("rst data", 32'(data), 32'd0);
    check("rst last", 32'(last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();

    // Plain Fibonacci.
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    run16("fib", 10, 16'd0, 16'd1, -1);

    // Lucas seeds.
    exp_q = '{2, 1, 3, 4, 7};
    run16("lucas", 5, 16'd2, 16'd1, -1);

    // Single term.
    exp_q = '{7};
    run16("single", 1, 16'd7, 16'd9, -1);

    // Start pulsed mid-burst is ignored.
    exp_q = '{0, 1, 1, 2};
    run16("midstart", 4, 16'd0, 16'd1, 1);
    step();
    check("midstart idle", 32'(valid), 32'd0);

    // term_count = 0 is ignored.
    seed0 = 16'd3; seed1 = 16'd4; tc = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("cnt0 valid", 32'(valid), 32'd0);
    check("cnt0 busy", 32'(busy), 32'd0);
    step();
    check("cnt0 valid2", 32'(valid), 32'd0);

    // Backpressure: stall 3 cycles at term 2, then toggle ready.
    exp_q = '{0, 1, 1, 2, 3, 5};
    seed0 = 16'd0; seed1 = 16'd1; tc = 8'd6; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    idx = 0; stall = 0; tog = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      if (idx == 2 && stall < 3) begin
        ready = 1'b0; stall++;
      end else if (idx > 2) begin
        ready = tog; tog = ~tog;
      end else begin
        ready = 1'b1;
      end
      check($sformatf("bp valid c%0d", cyc), 32'(valid), 32'd1);
      check($sformatf("bp data c%0d", cyc), 32'(data), 32'(exp_q[idx]));
      check($sformatf("bp last c%0d", cyc), 32'(last), 32'(idx == 5));
      if (ready) idx++;
      step();
    end
    ready = 1'b1;
    check("bp done", 32'(idx), 32'd6);
    check("bp valid_end", 32'(valid), 32'd0);

    // 8-bit wrap vs saturate.
    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    seed0_8 = 8'd0; seed1_8 = 8'd1; tc8 = 8'd16; ready8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap data[%0d]", i), 32'(w_data), 32'(exp_q[i]));
      check($sformatf("sat data[%0d]", i), 32'(s_data), (i >= 14) ? 32'd255 : 32'(exp_q[i]));
      check($sformatf("wrap ovf[%0d]", i), 32'(w_ovf), 32'(i >= 14));
      check($sformatf("sat ovf[%0d]", i), 32'(s_ovf), 32'(i >= 14));
      check($sformatf("wrap last[%0d]", i), 32'(w_last), 32'(i == 15));
      check($sformatf("sat valid[%0d]", i), 32'(s_valid), 32'd1);
      step();
    end
    check("wrap valid_end", 32'(w_valid), 32'd0);
    check("wrap ovf_idle", 32'(w_ovf), 32'd1);

    // ovf survives an ignored zero-count start.
    tc8 = 8'd0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("wrap cnt0 valid", 32'(w_valid), 32'd0);
    check("wrap cnt0 ovf", 32'(w_ovf), 32'd1);
    check("sat cnt0 busy", 32'(s_busy), 32'd0);

    // Reset mid-burst after 3 beats.
    seed0 = 16'd0; seed1 = 16'd1; tc = 8'd10; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_rst data", 32'(data), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mrst valid", 32'(valid), 32'd0);
    check("mrst data", 32'(data), 32'd0);
    check("mrst last", 32'(last), 32'd0);
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst ovf", 32'(ovf), 32'd0);
    check("mrst wrap ovf", 32'(w_ovf), 32'd0);
    #2 rst = 1'b0;
    step();
    exp_q = '{0, 1, 1};
    run16("post_rst", 3, 16'd0, 16'd1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
Parametrised Fibonacci-class sequence generator with programmable seeds, a term count, and a valid/ready output stream. It is the next generation of the free-running 9-bit Fibonacci counter. It adds configurable width, arbitrary seeds (Fibonacci, Lucas or custom), backpressure, end-of-burst marking, overflow detection and an optional saturating mode. It sits between a control register block, which issues start requests, and any downstream stream consumer.

Parameters:
WIDTH, 16, data width of each term in bits (minimum 2).
CNT_W, 8, width of term_count; maximum burst is 2^CNT_W-1 terms.
SATURATE, 0, 0 = terms wrap modulo 2^WIDTH; 1 = terms clamp at 2^WIDTH-1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
seed0  in  WIDTH  first term, captured on accepted start.
seed1  in  WIDTH  second term, captured on accepted start.
term_count  in  CNT_W  number of terms to emit, captured on accepted start.
out_valid  out  1  out_data holds a valid term.
out_ready  in  1  consumer accepts the term when out_valid is also high.
out_data  out  WIDTH  current term.
out_last  out  1  high with the final term of a burst.
busy  out  1  high in RUN.
ovf  out  1  sticky overflow flag for the current/last burst.

Behaviour:
- Reset values, applied asynchronously on rst: state=IDLE; out_valid, out_last, busy and ovf = 0; out_data = 0; internal a, b and remaining = 0; internal overflow tags = 0.
- Internal registers:
  - a: current term, drives out_data.
  - b: next term.
  - remaining: terms left to emit.
  - a_ovf, b_ovf: tag bits marking a term as wrapped or clamped.
- FSM has two states, IDLE and RUN.
- IDLE:
  - out_valid=0, busy=0.
  - start=1 with term_count!=0: a<=seed0, b<=seed1, remaining<=term_count, ovf<=0, tags<=0, then go to RUN.
  - start=1 with term_count==0: ignored; stay IDLE; ovf unchanged.
- RUN:
  - out_valid=1, busy=1, out_data=a.
  - out_last=1 when remaining==1.
  - First term is visible the cycle after start (latency 1).
- Handshake, on out_valid&&out_ready:
  - a<=b; a_ovf<=b_ovf; b<=next; remaining<=remaining-1.
  - b_ovf<=carry|a_ovf|b_ovf, where next and carry come from the (WIDTH+1)-bit sum a+b.
  - ovf<=ovf|b_ovf, so ovf rises in the same cycle the first tagged term appears on out_data.
  - If remaining==1, go to IDLE instead; out_valid falls the next cycle and a/out_data keep the last term.
- Stall: while out_valid&&!out_ready, out_data, out_last and all internal state hold exactly. There is no timeout.
- Arithmetic:
  - SATURATE=0: next = sum modulo 2^WIDTH.
  - SATURATE=1: next = 2^WIDTH-1 when carry=1.
  - Tagging is identical in both modes.
- Throughput: one term per cycle while out_ready is held high.
- start asserted in RUN is ignored; there is no queuing or restart.
- ovf stays readable in IDLE until the next accepted start clears it.
- Reset mid-burst: the burst aborts immediately with no out_last; the next start works normally.
- term_count=1: emits seed0 only, with out_last=1.
- term_count=2: emits seed0 then seed1.

Optional Feature:
FIB_SEQ_GEN_INDEX_EN:
- Defined: adds output out_index, width CNT_W, giving the 0-based index of the current term. It is 0 on the first term, increments on each handshake, holds during stalls, and resets to 0 on rst and on accepted start.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=16, seed0=0, seed1=1, term_count=10, out_ready=1: out_data 0,1,1,2,3,5,8,13,21,34 on consecutive cycles; out_last only with 34; ovf=0; busy falls after the 10th beat.
- Lucas seeds: seed0=2, seed1=1, term_count=5 -> 2,1,3,4,7; out_last with 7.
- Backpressure, seeds 0/1, count 6: hold out_ready low 3 cycles at term 2 and toggle it thereafter -> out_data stable while stalled; sequence still 0,1,1,2,3,5; no duplicated or dropped beats.
- WIDTH=8, SATURATE=0, seeds 0/1, count 16:
  - terms 0..13 equal 0..233.
  - term 14 = 121 (377 mod 256), and ovf rises in the cycle it is presented.
  - term 15 = 98 (233+121 = 354, mod 256); ovf stays 1.
  - Repeat with SATURATE=1: terms 14 and 15 = 255.
- Edges:
  - term_count=0: start gives no out_valid.
  - term_count=1, seeds 7/9: single beat 7 with out_last.
  - start pulsed mid-burst: no effect.
- Reset mid-burst after 3 beats: all outputs return to 0 asynchronously; a fresh start with seeds 0/1, count 3 yields 0,1,1.
